// File: rtl/pll_nn_pkg.sv
// Shared definitions for the PLL gain-scheduling NN front end: fixed-point
// formats of the NN inputs and the feature-extractor state encoding.
package pll_nn_pkg;

  localparam int unsigned NN_W            = 8;
  localparam int unsigned NOISE_INT_BITS  = 3;
  localparam int unsigned NOISE_FRAC_BITS = 5;
  localparam int unsigned KP_INT_BITS     = 8;
  localparam int unsigned KP_FRAC_BITS    = 0;

  localparam logic [NN_W-1:0] NOISE_MOST_NEG = 8'h80;
  localparam logic [NN_W-1:0] NOISE_MAG_MAX  = 8'h7F;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } feat_state_e;

endpackage

// File: rtl/nn_win_accum.sv
// One window-accumulator channel: running sum of unsigned samples, cleared on
// window wrap, with the truncated window mean of (sum + current sample).
module nn_win_accum
  import pll_nn_pkg::*;
#(
  parameter int unsigned LOG2_WIN = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_clr,
  input  logic            i_add,
  input  logic            i_wrap,
  input  logic [NN_W-1:0] i_data,
  output logic [NN_W-1:0] o_avg
);

  localparam int unsigned ACC_W = NN_W + LOG2_WIN;

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_sum;

  assign w_sum = r_acc + ACC_W'(i_data);
  // Shift-right by LOG2_WIN as a slice: truncating divide by the window length.
  assign o_avg = w_sum[LOG2_WIN +: NN_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_add) begin
      r_acc <= i_wrap ? '0 : w_sum;
    end
  end

endmodule

// File: rtl/nn_feature_avg.sv
// Windowed averager producing avgn (mean |phase error|, 3.5) and avgkp
// (mean kp, 8.0) for the NN, delivered through a registered valid/ready port.
module nn_feature_avg
  import pll_nn_pkg::*;
#(
  parameter int unsigned LOG2_WIN = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            sample_valid,
  input  logic [NN_W-1:0] noise_in,
  input  logic [NN_W-1:0] kp_in,
  output logic [NN_W-1:0] avgn,
  output logic [NN_W-1:0] avgkp,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            overrun
);

  feat_state_e         r_state;
  logic [LOG2_WIN-1:0] r_cnt;

  logic            w_accept;
  logic            w_wrap;
  logic            w_clr;
  logic [NN_W-1:0] w_mag;
  logic [NN_W-1:0] w_avgn;
  logic [NN_W-1:0] w_avgkp;

  assign w_accept = (r_state == ACCUM) && en && sample_valid;
  assign w_wrap   = w_accept && (r_cnt == '1);
  assign w_clr    = !en || (r_state == IDLE);

  // Saturating magnitude: the most negative code has no positive twin.
  always_comb begin
    w_mag = noise_in;
    if (noise_in == NOISE_MOST_NEG) begin
      w_mag = NOISE_MAG_MAX;
    end else if (noise_in[NN_W-1]) begin
      w_mag = -noise_in;
    end
  end

  nn_win_accum #(.LOG2_WIN(LOG2_WIN)) u_acc_n (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_clr),
    .i_add  (w_accept),
    .i_wrap (w_wrap),
    .i_data (w_mag),
    .o_avg  (w_avgn)
  );

  nn_win_accum #(.LOG2_WIN(LOG2_WIN)) u_acc_k (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_clr),
    .i_add  (w_accept),
    .i_wrap (w_wrap),
    .i_data (kp_in),
    .o_avg  (w_avgkp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      avgn      <= '0;
      avgkp     <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (!en) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        overrun <= 1'b0;
      end else if (r_state == IDLE) begin
        r_state <= ACCUM;
        r_cnt   <= '0;
      end else if (w_accept) begin
        // Counter wraps to zero naturally on the final sample of a window.
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_wrap) begin
        avgn      <= w_avgn;
        avgkp     <= w_avgkp;
        out_valid <= 1'b1;
        if (out_valid && !out_ready) begin
          overrun <= 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/nn_feature_avg.md
# nn_feature_avg

Windowed feature extractor that produces the `avgn` and `avgkp` inputs for the PLL gain-scheduling neural network. It accumulates per-sample phase-error magnitude and proportional-gain values over fixed windows of 2^LOG2_WIN accepted samples. It emits the truncated window averages through a valid/ready output handshake. It sits between the PLL phase detector/loop filter and the neural-network inference block.

## Interface
- `LOG2_WIN`, default 4: log2 of window length in accepted samples; legal range 1..8.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `en`  in  1  enable; low forces IDLE and discards the partial window.
- `sample_valid`  in  1  the `noise_in`/`kp_in` pair is accepted this cycle (when in ACCUM).
- `noise_in`  in  8  signed phase error, two's complement, 3 integer bits / 5 fractional bits.
- `kp_in`  in  8  unsigned proportional gain, 8 integer bits / 0 fractional bits.
- `avgn`  out  8  unsigned mean of |noise_in|, 3.5 format.
- `avgkp`  out  8  unsigned mean of kp_in, 8.0 format.
- `out_valid`  out  1  `avgn`/`avgkp` hold an unconsumed result.
- `out_ready`  in  1  consumer accepts the result when high together with `out_valid` at a clock edge.
- `overrun`  out  1  sticky flag: an unconsumed result was overwritten.

## Operation
- Magnitude: |noise_in|, with saturation; 0x80 maps to 0x7F. Range 0..127.
- Accumulators: `acc_n` and `acc_k`, each 8+LOG2_WIN bits unsigned, no overflow possible. Sample counter is LOG2_WIN bits.
- FSM:
  - IDLE: accumulators and counter held at 0. `en`=1 → ACCUM at the next edge.
  - ACCUM: each `sample_valid` cycle adds the sample to the accumulators and increments the counter.
  - Final sample of a window (counter = 2^LOG2_WIN−1 and `sample_valid` high):
    - `avgn` ← (acc_n+|noise_in|)>>LOG2_WIN.
    - `avgkp` ← (acc_k+kp_in)>>LOG2_WIN.
    - Truncation, no rounding.
    - Accumulators and counter reset to 0 on the same edge, so windows run back-to-back with no dropped samples.
  - `en`=0 in any state → IDLE at the next edge. The partial window is discarded. `avgn`, `avgkp` and `out_valid` are unchanged; `overrun` is cleared.
- Output handshake:
  - `out_valid` sets at window completion.
  - `out_valid` clears at an edge where `out_ready`=1 and no new window completes.
  - Completion while `out_valid`=1 and `out_ready`=0: outputs overwritten, `out_valid` stays 1, `overrun` sets.
  - Completion with `out_ready`=1 on the same edge: new result loaded, `out_valid` stays 1, no overrun.
  - Outputs are stable while `out_valid`=1 except on overwrite.
- `sample_valid` is ignored in IDLE.

## Timing
- Reset values: `avgn`=0, `avgkp`=0, `out_valid`=0, `overrun`=0; FSM in IDLE; accumulators 0.
- Latency: the result is visible on outputs one edge after the final sample's acceptance edge. `out_valid` rises on that same edge.
- First sample can be accepted in the cycle after `en` rises (IDLE→ACCUM takes one edge).
- Throughput: one sample per cycle; one result per 2^LOG2_WIN accepted samples.
- Reset assertion mid-window immediately clears all state, including pending `out_valid`.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `pll_nn_pkg` holds:
  - Fixed-point format constants for noise (3.5) and kp (8.0).
  - The NN-input width (8).
  - The FSM state enum {IDLE, ACCUM}.
- Sub-module `nn_win_accum` (one accumulator channel: add, clear-on-wrap, shift-truncate), instantiated twice: once for magnitude, once for kp.
- Abs-saturate logic stays inline in the top.

## Test plan
- LOG2_WIN=4, `out_ready`=1, 16 samples `noise_in`=0x20, `kp_in`=0x40 → `avgn`=0x20, `avgkp`=0x40, `out_valid` high one cycle after the 16th sample, then low.
- 16 samples alternating `noise_in`=0x10/0xF0 → `avgn`=0x10. 16 samples `noise_in`=0x80 → `avgn`=0x7F.
- 15 samples `kp_in`=1 plus one `kp_in`=0 (sum 15) → `avgkp`=0 (truncation). 16 samples `kp_in`=0xFF → `avgkp`=0xFF.
- `out_ready`=0, 32 consecutive samples (kp 0x10 then 0x20) → after window 2: `avgkp`=0x20, `out_valid`=1, `overrun`=1. Deassert `en` → `overrun`=0.
- `en` dropped after 7 samples, then re-enabled and fed 16 samples `kp_in`=0x08 → `avgkp`=0x08; the partial window does not contribute.
- `rst_n` pulsed low while `out_valid`=1 and mid-window → all outputs 0 immediately. The next full window after release is averaged correctly.
